multiport_reg_file: RTL and testbench
=====================================

// Module: multiport_reg_file
// PURPOSE
//  Parametrised register file with NUM_RD read ports and two write ports (WB, late/aux).
//  Adds same-cycle write->read bypass and a per-register pending scoreboard (reserve on issue, clear on write).
//  Sits in ID stage; pending bits feed the hazard unit.
// PARAMETERS
//  WIDTH      32  data word width
//  DEPTH      16  number of registers
//  ADDR_W     4   address width; must satisfy 2**ADDR_W >= DEPTH
//  NUM_RD     2   number of read ports
//  ZERO_REG   0   1: register 0 reads 0, ignores writes, never pending
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  rst        in   1               asynchronous reset, active-high
//  rd_addr    in   NUM_RD*ADDR_W   read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*WIDTH    read data, combinational, per-port slice as rd_addr
//  rd_pending out  NUM_RD          1 = register at rd_addr[k] awaits a writeback
//  wr0_en     in   1               write port 0 (WB) enable
//  wr0_addr   in   ADDR_W          write port 0 address
//  wr0_data   in   WIDTH           write port 0 data
//  wr1_en     in   1               write port 1 (aux) enable
//  wr1_addr   in   ADDR_W          write port 1 address
//  wr1_data   in   WIDTH           write port 1 data
//  rsv_en     in   1               reserve: mark rsv_addr pending
//  rsv_addr   in   ADDR_W          register to reserve
//  flush      in   1               synchronous: clear all pending bits
// BEHAVIOUR
//  Reset (async, rst=1): reg[i] = i truncated to WIDTH (reg[0]=0 if ZERO_REG); all pending = 0.
//   Outputs are combinational from that state. rst mid-cycle overrides any write/reserve/flush.
//  Write: posedge clk, wr0_en -> reg[wr0_addr]=wr0_data; wr1_en -> reg[wr1_addr]=wr1_data.
//   Both enabled, same address: port 1 wins.
//   Address >= DEPTH: write ignored. ZERO_REG=1 and address 0: write ignored.
//  Read: rd_data[k] = reg[rd_addr[k]], zero latency.
//   Bypass: if a write port is enabled to rd_addr[k] this cycle, return its data instead.
//   Port 1 has bypass priority over port 0. No bypass for ignored writes (0 / out-of-range).
//   Address >= DEPTH reads 0; ZERO_REG=1 and address 0 reads 0.
//  Pending (posedge, after rst):
//   flush=1: all bits -> 0; rsv_en is ignored that cycle (flush dominates).
//   else: any enabled write clears pending[wr addr] (both ports).
//   else: rsv_en sets pending[rsv_addr]; reserve beats a clear of the same address in the same cycle (new producer).
//   Reserve of an already-pending register: stays 1. Out-of-range / ZERO_REG reg0 reserve: ignored.
//   rd_pending[k] = pending[rd_addr[k]] AND NOT (a valid write to rd_addr[k] this cycle),
//   i.e. bypass resolves the hazard combinationally. Out-of-range reads -> 0.
//  No internal FSM beyond storage and pending bits. All ports are independent; any combination
//   of enables in one cycle is legal.
// TESTING
//  1 Reset: rst=1 -> rd_addr={3,7} gives rd_data={3,7}, rd_pending=0; with ZERO_REG=1, addr 0 -> 0.
//  2 Write/read: wr0 addr5=0xDEAD_BEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF.
//    Same cycle as write -> bypassed value.
//  3 Collision: wr0 & wr1 both addr9 (0x11 / 0x22) -> bypass 0x22 and stored 0x22;
//    ZERO_REG=1 write to 0 -> still reads 0.
//  4 Scoreboard: rsv addr4 -> next cycle rd_pending=1;
//    wr0 addr4 same cycle as read -> pending 0, data bypassed; next cycle pending 0.
//  5 Simultaneous rsv & wr on addr6 -> pending stays 1;
//    flush with rsv addr2 -> all pending 0, including addr2.
//  6 rst asserted mid-stream with pending bits set and writes active ->
//    immediate reg[i]=i and pending=0, without waiting for a clock edge.

Source files
------------

// File: rtl/multiport_reg_file.sv
// ---------------------------------------------------------------------------
// multiport_reg_file
//   Register file for the ID stage. It has NUM_RD combinational read ports and
//   two write ports: wr0 is writeback and wr1 is late/aux. A same-cycle write
//   is bypassed to the readers, and when both write ports hit one address,
//   port 1 takes priority. A per-register pending scoreboard marks a register
//   as reserved when an instruction issues and clears the mark when that
//   register is written. The hazard unit consumes the pending bits.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   rd_addr/rd_data      packed read ports; port k is slice k
//   rd_pending           pending bit per read port (hidden by same-cycle write)
//   wr0_en/addr/data     write port 0 (WB)
//   wr1_en/addr/data     write port 1 (aux); wins same-address collisions
//   rsv_en/rsv_addr      reserve a register (mark pending)
//   flush                clear all pending bits; dominates rsv_en
//
// An address >= DEPTH, or register 0 when ZERO_REG=1, is not usable. Such an
// address reads 0, ignores writes and reserves, and is never bypassed.
// ---------------------------------------------------------------------------
module multiport_reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [WIDTH-1:0]           wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [WIDTH-1:0]           wr1_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       flush
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;

    function automatic logic usable(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr0_ok = wr0_en && usable(wr0_addr);
    assign wr1_ok = wr1_en && usable(wr1_addr);
    assign rsv_ok = rsv_en && usable(rsv_addr);

    // Storage. Port 1 is written last, so its value wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= WIDTH'(i);
            end
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // Scoreboard. Clears are applied before the reserve, so a new producer
    // that issues in the same cycle as the old write keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (wr0_ok) pending[wr0_addr] <= 1'b0;
            if (wr1_ok) pending[wr1_addr] <= 1'b0;
            if (rsv_ok) pending[rsv_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  d;
        logic              p;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Bypass overrides both data and pending: the in-flight write is the
        // awaited producer, so the hazard is resolved this cycle.
        always_comb begin
            d = '0;
            p = 1'b0;
            if (usable(ra)) begin
                d = regs[ra];
                p = pending[ra];
                if (wr0_ok && (wr0_addr == ra)) begin
                    d = wr0_data;
                    p = 1'b0;
                end
                if (wr1_ok && (wr1_addr == ra)) begin
                    d = wr1_data;
                    p = 1'b0;
                end
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = d;
        assign rd_pending[k]             = p;
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pending;
    logic        wr0_en;
    logic [3:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [3:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        flush;

    // DEPTH=12 leaves addresses 12..15 out of range for boundary checks.
    multiport_reg_file #(
        .WIDTH(32),
        .DEPTH(12),
        .ADDR_W(4),
        .NUM_RD(2),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_pending(rd_pending),
        .wr0_en(wr0_en),
        .wr0_addr(wr0_addr),
        .wr0_data(wr0_data),
        .wr1_en(wr1_en),
        .wr1_addr(wr1_addr),
        .wr1_data(wr1_data),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        w0e;
        logic [3:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [31:0] w1d;
        logic        rse;
        logic [3:0]  rsa;
        logic        fl;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  ep;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  p;
    } exp_t;

    vec_t tbl[25];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push_exp(input string n, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [1:0] p);
        exp_t e;
        e.name = n;
        e.d0   = d0;
        e.d1   = d1;
        e.p    = p;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (rd_data[31:0] !== e.d0) begin
            n_fail++;
            $display("FAIL %s.d0: got %h required %h", e.name, rd_data[31:0], e.d0);
        end
        n_checks++;
        if (rd_data[63:32] !== e.d1) begin
            n_fail++;
            $display("FAIL %s.d1: got %h required %h", e.name, rd_data[63:32], e.d1);
        end
        n_checks++;
        if (rd_pending !== e.p) begin
            n_fail++;
            $display("FAIL %s.pend: got %b required %b", e.name, rd_pending, e.p);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check the
    // combinational outputs before the next rising edge commits the state.
    task automatic apply(input vec_t v);
        @(negedge clk);
        wr0_en   = v.w0e;
        wr0_addr = v.w0a;
        wr0_data = v.w0d;
        wr1_en   = v.w1e;
        wr1_addr = v.w1a;
        wr1_data = v.w1d;
        rsv_en   = v.rse;
        rsv_addr = v.rsa;
        flush    = v.fl;
        rd_addr  = {v.ra1, v.ra0};
        push_exp(v.name, v.ed0, v.ed1, v.ep);
        #2;
        check_pop();
    endtask

    task automatic idle_inputs();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    initial begin
        // name, w0e,w0a,w0d, w1e,w1a,w1d, rse,rsa, fl, ra0,ra1, ed0,ed1,ep
        tbl[0]  = '{"reset_rd",     1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd3,4'd7,   32'd3,32'd7,2'b00};
        tbl[1]  = '{"zero_rd",      1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd0,4'd11,  32'd0,32'd11,2'b00};
        tbl[2]  = '{"oor_rd",       1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd13,4'd15, 32'd0,32'd0,2'b00};
        tbl[3]  = '{"wr0_bypass",   1'b1,4'd5,32'hDEADBEEF, 1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd5,4'd4,   32'hDEADBEEF,32'd4,2'b00};
        tbl[4]  = '{"wr0_stored",   1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd5,4'd9,   32'hDEADBEEF,32'd9,2'b00};
        tbl[5]  = '{"coll_bypass",  1'b1,4'd9,32'h11,       1'b1,4'd9,32'h22, 1'b0,4'd0,  1'b0, 4'd9,4'd5,   32'h22,32'hDEADBEEF,2'b00};
        tbl[6]  = '{"ign_writes",   1'b1,4'd0,32'h55,       1'b1,4'd13,32'h77,1'b0,4'd0,  1'b0, 4'd9,4'd0,   32'h22,32'd0,2'b00};
        tbl[7]  = '{"ign_stored",   1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd0,4'd13,  32'd0,32'd0,2'b00};
        tbl[8]  = '{"rsv4",         1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd4,  1'b0, 4'd4,4'd4,   32'd4,32'd4,2'b00};
        tbl[9]  = '{"pend4",        1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd4,4'd3,   32'd4,32'd3,2'b01};
        tbl[10] = '{"wr4_bypass",   1'b1,4'd4,32'hA4,       1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd4,4'd4,   32'hA4,32'hA4,2'b00};
        tbl[11] = '{"pend4_clr",    1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd4,4'd4,   32'hA4,32'hA4,2'b00};
        tbl[12] = '{"rsv_wr6",      1'b0,4'd0,32'h0,        1'b1,4'd6,32'h66, 1'b1,4'd6,  1'b0, 4'd6,4'd6,   32'h66,32'h66,2'b00};
        tbl[13] = '{"pend6",        1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd6,4'd2,   32'h66,32'd2,2'b01};
        tbl[14] = '{"rsv2",         1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd2,  1'b0, 4'd6,4'd2,   32'h66,32'd2,2'b01};
        tbl[15] = '{"rsv6_again",   1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd6,  1'b0, 4'd6,4'd2,   32'h66,32'd2,2'b11};
        tbl[16] = '{"flush_rsv3",   1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd3,  1'b1, 4'd6,4'd2,   32'h66,32'd2,2'b11};
        tbl[17] = '{"flushed",      1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd6,4'd2,   32'h66,32'd2,2'b00};
        tbl[18] = '{"flushed_rsv3", 1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd3,4'd2,   32'd3,32'd2,2'b00};
        tbl[19] = '{"rsv_zero",     1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd0,  1'b0, 4'd0,4'd7,   32'd0,32'd7,2'b00};
        tbl[20] = '{"rsv_oor",      1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd13, 1'b0, 4'd0,4'd13,  32'd0,32'd0,2'b00};
        tbl[21] = '{"rsv_ign_chk",  1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd0,4'd13,  32'd0,32'd0,2'b00};
        tbl[22] = '{"rsv10",        1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b1,4'd10, 1'b0, 4'd10,4'd10, 32'd10,32'd10,2'b00};
        tbl[23] = '{"wr1_byp10",    1'b0,4'd0,32'h0,        1'b1,4'd10,32'hAA,1'b0,4'd0,  1'b0, 4'd10,4'd11, 32'hAA,32'd11,2'b00};
        tbl[24] = '{"pend10_clr",   1'b0,4'd0,32'h0,        1'b0,4'd0,32'h0,  1'b0,4'd0,  1'b0, 4'd10,4'd10, 32'hAA,32'hAA,2'b00};

        rst = 1'b1;
        idle_inputs();
        rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset in mid-stream, with pending bits set and writes active.
        @(negedge clk);
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 4'd5; rd_addr = {4'd7, 4'd5};
        push_exp("mid_pre0", 32'hDEADBEEF, 32'd7, 2'b00);
        #2; check_pop();

        @(negedge clk);
        rsv_addr = 4'd7;
        push_exp("mid_pre1", 32'hDEADBEEF, 32'd7, 2'b01);
        #2; check_pop();

        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h99;
        wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h33;
        rsv_addr = 4'd11;
        push_exp("mid_pending", 32'hDEADBEEF, 32'd7, 2'b11);
        #2; check_pop();
        #1 rst = 1'b1;
        push_exp("mid_rst_now", 32'd5, 32'd7, 2'b00);
        #1; check_pop();

        // Reset is held across a rising edge while writes and reserves stay active.
        @(negedge clk);
        push_exp("rst_hold", 32'd5, 32'd7, 2'b00);
        #2; check_pop();

        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        rd_addr = {4'd3, 4'd9};
        push_exp("rst_wr_ign", 32'd9, 32'd3, 2'b00);
        #2; check_pop();

        @(negedge clk);
        rd_addr = {4'd5, 4'd11};
        push_exp("rst_rsv_ign", 32'd11, 32'd5, 2'b00);
        #2; check_pop();

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_left: got %0d entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
